// File: rtl/truth_table_eval_seq_if.sv
// Handshake bundle for truth_table_eval_seq: configuration stream,
// input-vector channel, result channel and committed-table readback.
interface truth_table_eval_seq_if #(
  parameter int N_IN = 3
) ();
  localparam int D = 1 << N_IN;

  // Configuration channel
  logic            cfg_start;
  logic            cfg_valid;
  logic            cfg_bit;
  logic            cfg_ready;
  logic            cfg_done;
  // Input-vector channel
  logic            in_valid;
  logic            in_ready;
  logic [N_IN-1:0] in_bits;
  // Result channel
  logic            out_valid;
  logic            out_ready;
  logic            out;
  // Committed table readback
  logic [D-1:0]    table_q;

  // Block side
  modport slave (
    input  cfg_start, cfg_valid, cfg_bit, in_valid, in_bits, out_ready,
    output cfg_ready, cfg_done, in_ready, out_valid, out, table_q
  );

  // Driver / consumer side
  modport master (
    output cfg_start, cfg_valid, cfg_bit, in_valid, in_bits, out_ready,
    input  cfg_ready, cfg_done, in_ready, out_valid, out, table_q
  );
endinterface

// File: rtl/truth_table_eval_seq.sv
// Run-time-loadable N_IN-input truth-table cell. A table is streamed in
// MSB-first through the cfg channel and committed atomically; input vectors
// are evaluated against the committed table after a programmable settle
// latency and presented on a valid/ready result channel.
module truth_table_eval_seq #(
  parameter int                    N_IN       = 3,
  parameter logic [(1<<N_IN)-1:0]  INIT_TABLE = 8'hBF,
  parameter int                    SETTLE     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  truth_table_eval_seq_if.slave   bus
);
  localparam int D  = 1 << N_IN;
  localparam int BW = $clog2(D + 1);
  localparam int CW = $clog2(SETTLE + 1);

  localparam logic [BW-1:0] LAST_BIT    = BW'(D - 1);
  localparam logic [CW-1:0] SETTLE_INIT = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_HOLD
  } state_t;

  state_t          state;
  logic [D-1:0]    table_r;
  logic [D-1:0]    shadow;
  logic [D-1:0]    shadow_next;
  logic [BW-1:0]   bit_cnt;
  logic [CW-1:0]   settle_cnt;
  logic [N_IN-1:0] captured;
  logic            out_r;
  logic            out_valid_r;
  logic            cfg_ready_r;
  logic            cfg_done_r;

  // Shadow after accepting the current cfg bit; the first bit ends up in the MSB.
  assign shadow_next = {shadow[D-2:0], bus.cfg_bit};

  // Accept a vector only when idle and not being asked to reload the table.
  assign bus.in_ready  = (state == S_IDLE) && !bus.cfg_start;
  assign bus.cfg_ready = cfg_ready_r;
  assign bus.cfg_done  = cfg_done_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out       = out_r;
  assign bus.table_q   = table_r;

  // Control FSM with registered outputs: load, settle and hold sequencing.
  // NOTE: every register here is assigned with <= so all updates see the
  // pre-edge values; blocking assignments would create ordering-dependent logic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      // NOTE: the shadow and committed tables are reset too, so a partial
      // load can never survive a reset and table_q is defined immediately.
      table_r     <= INIT_TABLE;
      shadow      <= '0;
      bit_cnt     <= '0;
      settle_cnt  <= '0;
      captured    <= '0;
      out_r       <= 1'b0;
      out_valid_r <= 1'b0;
      cfg_ready_r <= 1'b0;
      cfg_done_r  <= 1'b0;
    end else begin
      cfg_done_r <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.cfg_start) begin
            bit_cnt     <= '0;
            cfg_ready_r <= 1'b1;
            state       <= S_LOAD;
          end else if (bus.in_valid) begin
            captured   <= bus.in_bits;
            settle_cnt <= SETTLE_INIT;
            state      <= S_SETTLE;
          end
        end
        S_LOAD: begin
          if (bus.cfg_valid) begin
            shadow  <= shadow_next;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              table_r     <= shadow_next;
              cfg_done_r  <= 1'b1;
              cfg_ready_r <= 1'b0;
              state       <= S_IDLE;
            end
          end
        end
        S_SETTLE: begin
          if (settle_cnt == '0) begin
            // D-1-idx equals the bitwise inverse of idx over N_IN bits.
            out_r       <= table_r[~captured];
            out_valid_r <= 1'b1;
            state       <= S_HOLD;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/truth_table_eval_seq.md
Name: truth_table_eval_seq

Overview:
- Sequential, parametrised successor to the fixed 3-input truth-table gate modules (e.g. Wolfram function 0xBF).
- Holds a run-time-loadable truth table for N_IN inputs and evaluates input vectors through a valid/ready handshake.
- Models circuit settling delay with a programmable latency.
- Serves as the reusable logic-function cell for compiled netlist simulation and emulation.

Parameters:
- N_IN, 3, number of logic inputs (1..8); table depth D = 2^N_IN.
- INIT_TABLE, 8'hBF, reset truth table, D bits wide.
- SETTLE, 4, evaluation latency in cycles (>= 1).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- cfg_start  input  1  request to reload the truth table.
- cfg_valid  input  1  cfg_bit is valid this cycle.
- cfg_bit  input  1  serial table bit.
- cfg_ready  output  1  block is accepting config bits.
- cfg_done  output  1  one-cycle pulse: new table committed.
- in_valid  input  1  in_bits is valid this cycle.
- in_ready  output  1  block accepts an input vector this cycle.
- in_bits  input  N_IN  input vector; in_bits[N_IN-1] is in1 (MSB).
- out_valid  output  1  out is valid.
- out_ready  input  1  consumer accepts out.
- out  output  1  function result.
- table_q  output  D  committed truth table (readback).

Behaviour:
- Table convention:
  - idx = unsigned value of in_bits.
  - out = table[D-1-idx], so the table MSB is the entry for idx 0.
  - With the default 8'hBF: idx 1 gives 0; every other idx gives 1.
- Reset (async, active-high):
  - Table and table_q = INIT_TABLE; any shadow table is discarded.
  - State = IDLE; bit counter = 0; settle counter = 0.
  - out = 0, out_valid = 0, cfg_ready = 0, cfg_done = 0.
- States and outputs:
  - IDLE: in_ready = !cfg_start.
  - LOAD: cfg_ready = 1; in_ready = 0.
  - SETTLE: in_ready = 0.
  - HOLD: out_valid = 1; in_ready = 0.
- IDLE transitions:
  - cfg_start=1 -> LOAD, bit counter = 0. cfg_start has priority over a simultaneous in_valid; that input is not accepted.
  - else in_valid=1 -> capture in_bits, counter = SETTLE-1, go to SETTLE.
- LOAD:
  - Each cycle with cfg_valid=1, shift cfg_bit into the shadow table MSB-first; the first bit is the entry for idx 0.
  - On the D-th accepted bit: commit the shadow to the table atomically at that edge; cfg_done = 1 on the next cycle only; go to IDLE.
  - cfg_valid=0 stalls the load indefinitely.
  - cfg_start while in LOAD is ignored.
  - Evaluation always uses the committed table; the shadow is never visible on table_q before commit.
- SETTLE:
  - Counter decrements each cycle.
  - At 0: register out = table[D-1-idx] using the captured input; set out_valid = 1; go to HOLD.
  - Latency: input accepted at edge T gives out_valid at edge T+SETTLE.
- HOLD:
  - out and out_valid are held stable while out_ready=0.
  - On out_ready=1: out_valid -> 0 at the next edge; go to IDLE. out keeps its last value.
  - The next input can be accepted one cycle after the handshake.
- Outside states:
  - cfg_valid, cfg_bit and cfg_start outside their states are ignored (cfg_start is only sampled in IDLE).
  - in_bits changes after capture do not affect the result.
- Reset mid-operation (any state): return to the reset condition. A partial load is discarded and the table reverts to INIT_TABLE.
- Widths:
  - Bit counter: clog2(D+1) bits.
  - Settle counter: clog2(SETTLE+1) bits.
  - No wrap-around; the counters are reinitialised on every entry to their state.

Test Plan:
1. Default table after reset; sweep in_bits 000..111 with out_ready=1 -> out = 1,0,1,1,1,1,1,1; each out_valid exactly 4 cycles after acceptance; table_q = 8'hBF.
2. cfg_start, then bits 0,0,0,0,0,0,0,1 (one gap cycle with cfg_valid=0) -> cfg_done single pulse one cycle after the 8th bit; table_q = 8'h01; inputs 111 -> 1, 110 -> 0.
3. Backpressure: evaluate 001, hold out_ready=0 for 10 cycles with in_valid=1 -> out_valid=1 and out=0 stable; in_ready=0; no new capture. Release -> out_valid falls next edge.
4. Reset asserted after 5 config bits of 8'h00 -> table_q = 8'hBF immediately, cfg_ready=0, cfg_done never pulses; next input 001 -> 0, 000 -> 1.
5. cfg_start and in_valid both high in IDLE -> in_ready=0 that cycle; state goes to LOAD; no out_valid is produced for that vector.
6. N_IN=2, INIT_TABLE=4'h6, SETTLE=1 -> XOR truth table: 00->0, 01->1, 10->1, 11->0, each with 1-cycle latency.
